mem_line_refill: RTL and testbench

//  Cache-side refill/evict engine feeding the single-port test memory.

---
 rtl/mem_line_refill_if.sv | 68 ++++++
 rtl/mem_line_refill.sv | 176 +++++++++++++++++
 tb/tb_mem_line_refill.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_line_refill_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_line_refill_if
// Description : Line-side and word-side val/rdy bundle for the line refill
//               engine. The master modport is the refill engine; the slave
//               modport is the cache plus test memory environment.
//               Word messages use the packed test-memory layouts:
//                 request  = {type[2:0], opaque, addr, len, data}
//                 response = {type[2:0], opaque, test[1:0], len, data}
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_line_refill_if #(
    parameter int P_OPAQUE_NBITS = 8,
    parameter int P_ADDR_NBITS   = 32,
    parameter int P_DATA_NBITS   = 32,
    parameter int P_LINE_NWORDS  = 4
);
    localparam int c_len_nbits  = $clog2(P_DATA_NBITS / 8);
    localparam int c_line_nbits = P_LINE_NWORDS * P_DATA_NBITS;
    localparam int c_req_nbits  = 3 + P_OPAQUE_NBITS + P_ADDR_NBITS + c_len_nbits + P_DATA_NBITS;
    localparam int c_resp_nbits = 3 + P_OPAQUE_NBITS + 2 + c_len_nbits + P_DATA_NBITS;

    // Line request from the cache
    logic                      linereq_val;
    logic                      linereq_rdy;
    logic                      linereq_type;
    logic [P_OPAQUE_NBITS-1:0] linereq_opaque;
    logic [P_ADDR_NBITS-1:0]   linereq_addr;
    logic [c_line_nbits-1:0]   linereq_data;

    // Line response to the cache
    logic                      lineresp_val;
    logic                      lineresp_rdy;
    logic                      lineresp_type;
    logic [P_OPAQUE_NBITS-1:0] lineresp_opaque;
    logic [c_line_nbits-1:0]   lineresp_data;

    // Word request/response to the test memory
    logic                      memreq_val;
    logic                      memreq_rdy;
    logic [c_req_nbits-1:0]    memreq_msg;
    logic                      memresp_val;
    logic                      memresp_rdy;
    logic [c_resp_nbits-1:0]   memresp_msg;

    modport master (
        input  linereq_val, linereq_type, linereq_opaque, linereq_addr, linereq_data,
        output linereq_rdy,
        output lineresp_val, lineresp_type, lineresp_opaque, lineresp_data,
        input  lineresp_rdy,
        output memreq_val, memreq_msg,
        input  memreq_rdy,
        input  memresp_val, memresp_msg,
        output memresp_rdy
    );

    modport slave (
        output linereq_val, linereq_type, linereq_opaque, linereq_addr, linereq_data,
        input  linereq_rdy,
        input  lineresp_val, lineresp_type, lineresp_opaque, lineresp_data,
        output lineresp_rdy,
        input  memreq_val, memreq_msg,
        output memreq_rdy,
        output memresp_val, memresp_msg,
        input  memresp_rdy
    );
endinterface
`default_nettype wire

// File: rtl/mem_line_refill.sv
`default_nettype none
// ============================================================================
// Module      : mem_line_refill
// Description : Accepts one cache-line read/write, issues it as back-to-back
//               word requests to the test memory, gathers the word responses
//               into a line buffer and returns a single line response.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_line_refill #(
    parameter int P_OPAQUE_NBITS = 8,
    parameter int P_ADDR_NBITS   = 32,
    parameter int P_DATA_NBITS   = 32,
    parameter int P_LINE_NWORDS  = 4
) (
    input  logic              clk,
    input  logic              reset,
    mem_line_refill_if.master bus
);
    localparam int c_idx_bits      = $clog2(P_LINE_NWORDS);
    localparam int c_cnt_bits      = c_idx_bits + 1;
    localparam int c_byte_bits     = $clog2(P_DATA_NBITS / 8);
    localparam int c_off_bits      = c_idx_bits + c_byte_bits;
    localparam int c_len_nbits     = c_byte_bits;
    localparam int c_line_nbits    = P_LINE_NWORDS * P_DATA_NBITS;
    localparam int c_resp_opq_lsb  = P_DATA_NBITS + c_len_nbits + 2;
    localparam int c_resp_type_lsb = c_resp_opq_lsb + P_OPAQUE_NBITS;

    localparam logic [2:0]              c_type_read  = 3'd0;
    localparam logic [2:0]              c_type_write = 3'd1;
    localparam logic [c_cnt_bits-1:0]   c_nwords     = c_cnt_bits'(P_LINE_NWORDS);
    localparam logic [c_cnt_bits-1:0]   c_last_word  = c_cnt_bits'(P_LINE_NWORDS - 1);
    localparam logic [P_ADDR_NBITS-1:0] c_off_mask   = P_ADDR_NBITS'((64'd1 << c_off_bits) - 64'd1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_next;

    logic                      r_type;
    logic [P_OPAQUE_NBITS-1:0] r_opaque;
    logic [P_ADDR_NBITS-1:0]   r_base;
    logic [c_line_nbits-1:0]   r_wdata;
    logic [c_line_nbits-1:0]   r_line;
    logic [c_cnt_bits-1:0]     r_issue_cnt;
    logic [c_cnt_bits-1:0]     r_recv_cnt;

    logic                      w_linereq_fire;
    logic                      w_memreq_fire;
    logic                      w_memresp_fire;
    logic [c_idx_bits-1:0]     w_issue_idx;
    logic [c_idx_bits-1:0]     w_resp_idx;
    logic [P_DATA_NBITS-1:0]   w_resp_data;
    logic [2:0]                w_resp_type;
    logic [2:0]                w_line_type;
    logic [P_OPAQUE_NBITS-1:0] w_req_opaque;
    logic [P_ADDR_NBITS-1:0]   w_req_addr;
    logic [P_DATA_NBITS-1:0]   w_req_data;

    assign w_linereq_fire = bus.linereq_val && bus.linereq_rdy;
    assign w_memreq_fire  = bus.memreq_val  && bus.memreq_rdy;
    assign w_memresp_fire = bus.memresp_val && bus.memresp_rdy;

    // Word slot of the next request; the response carries its slot back in
    // the low opaque bits, so responses may be collected in any order.
    assign w_issue_idx = r_issue_cnt[c_idx_bits-1:0];
    assign w_resp_idx  = bus.memresp_msg[c_resp_opq_lsb +: c_idx_bits];
    assign w_resp_data = bus.memresp_msg[P_DATA_NBITS-1:0];
    assign w_resp_type = bus.memresp_msg[c_resp_type_lsb +: 3];
    assign w_line_type = r_type ? c_type_write : c_type_read;

    // The base is line aligned, so OR-ing in the word offset is an add.
    assign w_req_opaque = P_OPAQUE_NBITS'(w_issue_idx);
    assign w_req_addr   = r_base | (P_ADDR_NBITS'(w_issue_idx) << c_byte_bits);
    assign w_req_data   = r_type ? r_wdata[w_issue_idx * P_DATA_NBITS +: P_DATA_NBITS]
                                 : '0;

    assign bus.memreq_msg      = {w_line_type, w_req_opaque, w_req_addr,
                                  {c_len_nbits{1'b0}}, w_req_data};
    assign bus.lineresp_type   = r_type;
    assign bus.lineresp_opaque = r_opaque;
    assign bus.lineresp_data   = r_line;

    // State register; reset aborts any line in flight without a response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and handshake outputs; every val/rdy is held low in reset.
    always_comb begin
        w_state_next     = r_state;
        bus.linereq_rdy  = 1'b0;
        bus.lineresp_val = 1'b0;
        bus.memreq_val   = 1'b0;
        bus.memresp_rdy  = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.linereq_rdy = reset;
                if (reset && bus.linereq_val) begin
                    w_state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                bus.memreq_val  = reset && (r_issue_cnt < c_nwords);
                bus.memresp_rdy = reset;
                if (reset && bus.memresp_val && (r_recv_cnt == c_last_word)) begin
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                bus.lineresp_val = reset;
                if (reset && bus.lineresp_rdy) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Line context capture, issue/collect counters and the line buffer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_type      <= 1'b0;
            r_opaque    <= '0;
            r_base      <= '0;
            r_wdata     <= '0;
            r_line      <= '0;
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
        end else begin
            if (w_linereq_fire) begin
                r_type      <= bus.linereq_type;
                r_opaque    <= bus.linereq_opaque;
                r_base      <= bus.linereq_addr & ~c_off_mask;
                r_wdata     <= bus.linereq_data;
                r_line      <= '0;
                r_issue_cnt <= '0;
                r_recv_cnt  <= '0;
            end
            if (w_memreq_fire) begin
                r_issue_cnt <= r_issue_cnt + 1'b1;
            end
            if (w_memresp_fire) begin
                r_recv_cnt <= r_recv_cnt + 1'b1;
                if (!r_type) begin
                    r_line[w_resp_idx * P_DATA_NBITS +: P_DATA_NBITS] <= w_resp_data;
                end
            end
        end
    end

    // Inputs from the environment must never be unknown outside reset.
    a_linereq_val_known: assert property (@(posedge clk) disable iff (!reset)
        !$isunknown(bus.linereq_val));
    a_lineresp_rdy_known: assert property (@(posedge clk) disable iff (!reset)
        !$isunknown(bus.lineresp_rdy));
    a_memreq_rdy_known: assert property (@(posedge clk) disable iff (!reset)
        !$isunknown(bus.memreq_rdy));
    a_memresp_val_known: assert property (@(posedge clk) disable iff (!reset)
        !$isunknown(bus.memresp_val));
    a_memresp_msg_known: assert property (@(posedge clk) disable iff (!reset)
        bus.memresp_val |-> !$isunknown(bus.memresp_msg));
    // A word response must carry the same operation as the line in flight.
    a_memresp_type: assert property (@(posedge clk) disable iff (!reset)
        w_memresp_fire |-> (w_resp_type == w_line_type));
endmodule
`default_nettype wire

// File: tb/tb_mem_line_refill.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_line_refill
// Description : Self-checking bench for mem_line_refill. A behavioural word
//               memory with random handshake delays serves the engine; a
//               line-level reference memory predicts every line response.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_line_refill;
    localparam int c_w       = 4;
    localparam int c_timeout = 500;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_line_refill_if #(
        .P_OPAQUE_NBITS (8),
        .P_ADDR_NBITS   (32),
        .P_DATA_NBITS   (32),
        .P_LINE_NWORDS  (c_w)
    ) bus ();

    mem_line_refill #(
        .P_OPAQUE_NBITS (8),
        .P_ADDR_NBITS   (32),
        .P_DATA_NBITS   (32),
        .P_LINE_NWORDS  (c_w)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Word memory serving the engine, and its handshake behaviour
    int           rdy_pct = 100;
    int           val_pct = 100;
    logic [31:0]  mem_words [int unsigned];
    logic [46:0]  resp_q [$];

    // Line in flight as the bench issued it
    logic         cur_type   = 1'b0;
    logic [31:0]  cur_base   = '0;
    logic [127:0] cur_wdata  = '0;
    int           mem_issued = 0;
    int           t_accept   = 0;

    // Line-level reference memory
    logic [31:0]  ref_words [int unsigned];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One word request accepted by the memory: check it, perform it, queue reply.
    task automatic mem_access();
        logic [76:0] m;
        logic [2:0]  typ;
        logic [7:0]  opq;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
        logic [31:0] rdata;
        m     = bus.memreq_msg;
        typ   = m[76:74];
        opq   = m[73:66];
        addr  = m[65:34];
        len   = m[33:32];
        data  = m[31:0];
        rdata = '0;
        check("memreq_order", opq, mem_issued);
        check("memreq_type", typ, {2'b00, cur_type});
        check("memreq_addr", addr, cur_base + 32'(mem_issued * 4));
        check("memreq_len", len, 0);
        check("memreq_data", data, cur_type ? cur_wdata[mem_issued * 32 +: 32] : 32'h0);
        if (typ == 3'd1) begin
            mem_words[addr >> 2] = data;
        end else if (mem_words.exists(addr >> 2)) begin
            rdata = mem_words[addr >> 2];
        end
        resp_q.push_back({typ, opq, 2'b00, 2'b00, rdata});
        mem_issued++;
    endtask

    // Test memory: drives its side at negedge, observes handshakes just after.
    always @(negedge clk) begin
        if (!reset) begin
            resp_q.delete();
            bus.memreq_rdy  = 1'b0;
            bus.memresp_val = 1'b0;
            bus.memresp_msg = '0;
        end else begin
            bus.memreq_rdy = ($urandom_range(0, 99) < 32'(rdy_pct));
            if (resp_q.size() > 0 && $urandom_range(0, 99) < 32'(val_pct)) begin
                bus.memresp_val = 1'b1;
                bus.memresp_msg = resp_q[0];
            end else begin
                bus.memresp_val = 1'b0;
                bus.memresp_msg = '0;
            end
            #1;
            if (bus.memresp_val && bus.memresp_rdy) void'(resp_q.pop_front());
            if (bus.memreq_val && bus.memreq_rdy) mem_access();
        end
    end

    task automatic send_line(input logic t, input logic [7:0] op, input logic [31:0] addr,
                             input logic [127:0] wd, input bit b2b);
        int waited;
        waited = 0;
        @(negedge clk);
        bus.linereq_val    = 1'b1;
        bus.linereq_type   = t;
        bus.linereq_opaque = op;
        bus.linereq_addr   = addr;
        bus.linereq_data   = wd;
        #1;
        if (b2b) check("b2b_accept", bus.linereq_rdy, 1);
        while (!bus.linereq_rdy && waited < c_timeout) begin
            @(negedge clk);
            #1;
            waited++;
        end
        check("linereq_rdy_wait", bus.linereq_rdy, 1);
        cur_type   = t;
        cur_base   = addr & ~32'hF;
        cur_wdata  = wd;
        mem_issued = 0;
        t_accept   = cyc;
        @(negedge clk);
        bus.linereq_val = 1'b0;
    endtask

    task automatic recv_line(input logic t, input logic [7:0] op, input logic [127:0] exp,
                             input int stall, input bit rnd, input bit chk_lat,
                             output logic [127:0] rdata);
        bit           seen;
        bit           done;
        int           left;
        int           waited;
        logic [127:0] cap;
        seen   = 0;
        done   = 0;
        left   = stall;
        waited = 0;
        cap    = '0;
        rdata  = '0;
        while (!done && waited < c_timeout) begin
            if (rnd) bus.lineresp_rdy = 1'($urandom_range(0, 1));
            else     bus.lineresp_rdy = (stall == 0) || (seen && left == 0);
            #1;
            if (seen) begin
                check("hold_val", bus.lineresp_val, 1);
                check("hold_data", bus.lineresp_data, cap);
                check("hold_linereq_rdy", bus.linereq_rdy, 0);
            end
            if (bus.lineresp_val) begin
                if (!seen) begin
                    seen = 1;
                    cap  = bus.lineresp_data;
                end
                if (bus.lineresp_rdy) begin
                    done  = 1;
                    rdata = bus.lineresp_data;
                    check("resp_type", bus.lineresp_type, t);
                    check("resp_opaque", bus.lineresp_opaque, op);
                    check("resp_data", bus.lineresp_data, exp);
                    check("resp_nwords", mem_issued, c_w);
                    if (chk_lat) check("resp_latency", cyc - t_accept, c_w + 2);
                end else if (left > 0) begin
                    left--;
                end
            end
            if (!done) begin
                @(negedge clk);
                waited++;
            end
        end
        check("lineresp_wait", done, 1);
    endtask

    // Predict the response from the reference memory, then run the line.
    task automatic do_line(input logic t, input logic [7:0] op, input logic [31:0] addr,
                           input logic [127:0] wd, input int stall, input bit rnd,
                           input bit chk_lat, input bit b2b, output logic [127:0] rdata);
        logic [31:0]  base;
        logic [127:0] exp;
        int unsigned  k;
        base = addr & ~32'hF;
        exp  = '0;
        for (int i = 0; i < c_w; i++) begin
            k = (base >> 2) + i;
            if (t) ref_words[k] = wd[i * 32 +: 32];
            else if (ref_words.exists(k)) exp[i * 32 +: 32] = ref_words[k];
        end
        send_line(t, op, addr, wd, b2b);
        recv_line(t, op, exp, stall, rnd, chk_lat, rdata);
    endtask

    initial begin
        logic [127:0] rd;
        int           waited;
        bus.linereq_val    = 1'b0;
        bus.linereq_type   = 1'b0;
        bus.linereq_opaque = '0;
        bus.linereq_addr   = '0;
        bus.linereq_data   = '0;
        bus.lineresp_rdy   = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_linereq_rdy", bus.linereq_rdy, 0);
        check("rst_lineresp_val", bus.lineresp_val, 0);
        check("rst_memreq_val", bus.memreq_val, 0);
        check("rst_memresp_rdy", bus.memresp_rdy, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("idle_linereq_rdy", bus.linereq_rdy, 1);

        // Write line, then unaligned read of the same line
        do_line(1'b1, 8'h11, 32'h100, {32'h33, 32'h22, 32'h11, 32'h00}, 0, 0, 1, 0, rd);
        check("t1_data", rd, 128'h0);
        do_line(1'b0, 8'h5A, 32'h10C, '0, 0, 0, 1, 0, rd);
        check("t2_data", rd, {32'h33, 32'h22, 32'h11, 32'h00});

        // Response backpressure for five cycles
        do_line(1'b0, 8'hC3, 32'h104, '0, 5, 0, 0, 0, rd);

        // Random memory delays and random line backpressure
        rdy_pct = 60;
        val_pct = 60;
        for (int n = 0; n < 20; n++) begin
            do_line(1'($urandom_range(0, 1)), 8'($urandom), 32'($urandom_range(0, 32'h7F)),
                    {$urandom, $urandom, $urandom, $urandom}, 0, 1, 0, 0, rd);
        end
        rdy_pct = 100;
        val_pct = 100;

        // Reset in the middle of a read line after two words issued
        send_line(1'b0, 8'h77, 32'h100, '0, 0);
        waited = 0;
        while (mem_issued < 2 && waited < c_timeout) begin
            @(negedge clk);
            #2;
            waited++;
        end
        check("t5_two_issued", mem_issued, 2);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("t5_linereq_rdy", bus.linereq_rdy, 0);
        check("t5_lineresp_val", bus.lineresp_val, 0);
        check("t5_memreq_val", bus.memreq_val, 0);
        check("t5_memresp_rdy", bus.memresp_rdy, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("t5_idle_linereq_rdy", bus.linereq_rdy, 1);
        do_line(1'b0, 8'h78, 32'h108, '0, 0, 0, 1, 0, rd);
        check("t5_data", rd, {32'h33, 32'h22, 32'h11, 32'h00});

        // Back-to-back lines with the response always accepted
        do_line(1'b1, 8'h21, 32'h180, {32'hDEADBEEF, 32'hCAFEF00D, 32'h12345678, 32'h9ABCDEF0},
                0, 0, 1, 1, rd);
        do_line(1'b0, 8'h22, 32'h184, '0, 0, 0, 1, 1, rd);
        check("t6_data", rd, {32'hDEADBEEF, 32'hCAFEF00D, 32'h12345678, 32'h9ABCDEF0});
        do_line(1'b1, 8'h23, 32'h190, {32'h4, 32'h3, 32'h2, 32'h1}, 0, 0, 1, 1, rd);
        do_line(1'b0, 8'h24, 32'h19F, '0, 0, 0, 1, 1, rd);
        check("t6_data2", rd, {32'h4, 32'h3, 32'h2, 32'h1});

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
